// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of vga_timing_gen: lookup addresses out, returned pixel data in, aligned DAC signals out.
// master = timing generator, slave = font/VRAM path plus DAC consumer.
interface vga_timing_gen_if #(
   parameter int CW     = 4,
   parameter int ADDR_W = 10
);
   logic [3*CW-1:0]   vga_data;
   logic [ADDR_W-1:0] h_addr;
   logic [ADDR_W-1:0] v_addr;
   logic [6:0]        h_char;
   logic [4:0]        v_char;
   logic [3:0]        h_font;
   logic [3:0]        v_font;
   logic              addr_valid;
   logic              frame_start;
   logic              hsync;
   logic              vsync;
   logic              valid;
   logic [CW-1:0]     vga_r;
   logic [CW-1:0]     vga_g;
   logic [CW-1:0]     vga_b;
`ifdef VGA_TEST_PATTERN_EN
   logic              test_mode;
`endif

   modport master (
      input  vga_data,
      output h_addr, v_addr, h_char, v_char, h_font, v_font, addr_valid, frame_start,
      output hsync, vsync, valid, vga_r, vga_g, vga_b
`ifdef VGA_TEST_PATTERN_EN
      , input test_mode
`endif
   );

   modport slave (
      output vga_data,
      input  h_addr, v_addr, h_char, v_char, h_font, v_font, addr_valid, frame_start,
      input  hsync, vsync, valid, vga_r, vga_g, vga_b
`ifdef VGA_TEST_PATTERN_EN
      , output test_mode
`endif
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing with character-cell addresses; VGA_TEST_PATTERN_EN adds test_mode colour bars.
// Addresses undelayed; hsync/vsync/valid/colour lag h_addr by DATA_LAT+1 cycles; free-running, no backpressure.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int FONT_W   = 9,
   parameter int FONT_H   = 16,
   parameter int CW       = 4,
   parameter int DATA_LAT = 1,
   parameter int ADDR_W   = 10
) (
   input  logic             pclk,
   input  logic             reset,
   vga_timing_gen_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W    = $clog2(H_TOTAL + 1);
   localparam int VC_W    = $clog2(V_TOTAL + 1);

   localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]      FW_LAST = 4'(FONT_W - 1);
   localparam logic [3:0]      FH_LAST = 4'(FONT_H - 1);
   localparam logic            HS_LVL  = (HS_POL != 0);
   localparam logic            VS_LVL  = (VS_POL != 0);

   logic [HC_W-1:0] h_cnt_q, h_cnt_d;
   logic [VC_W-1:0] v_cnt_q, v_cnt_d;
   logic [3:0]      h_font_q, h_font_d, v_font_q, v_font_d;
   logic [6:0]      h_char_q, h_char_d;
   logic [4:0]      v_char_q, v_char_d;
   logic            h_wrap, v_wrap, h_act, v_act;
   logic            hs_raw, vs_raw, av_raw;

   always_comb begin
      h_wrap  = (h_cnt_q == H_LAST);
      v_wrap  = (v_cnt_q == V_LAST);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end
      h_act  = (h_cnt_q < H_ACT);
      v_act  = (v_cnt_q < V_ACT);
      av_raw = h_act && v_act;
      hs_raw = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      vs_raw = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
   end

   // Cell sub-counters track the next counter value, so they match h_addr/v_addr without a divider.
   always_comb begin
      h_font_d = '0;
      h_char_d = '0;
      if (!h_wrap && (h_cnt_d < H_ACT)) begin
         if (h_font_q == FW_LAST) begin
            h_char_d = h_char_q + 1'b1;
         end else begin
            h_font_d = h_font_q + 1'b1;
            h_char_d = h_char_q;
         end
      end
      v_font_d = v_font_q;
      v_char_d = v_char_q;
      if (h_wrap) begin
         v_font_d = '0;
         v_char_d = '0;
         if (!v_wrap && (v_cnt_d < V_ACT)) begin
            if (v_font_q == FH_LAST) begin
               v_char_d = v_char_q + 1'b1;
            end else begin
               v_font_d = v_font_q + 1'b1;
               v_char_d = v_char_q;
            end
         end
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         h_font_q <= '0;
         h_char_q <= '0;
         v_font_q <= '0;
         v_char_q <= '0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         h_font_q <= h_font_d;
         h_char_q <= h_char_d;
         v_font_q <= v_font_d;
         v_char_q <= v_char_d;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);

   logic [BC_W-1:0] bar_pix_q, bar_pix_d;
   logic [2:0]      bar_idx_q, bar_idx_d;

   // Index saturates at 7 so a remainder of H_ACTIVE/8 stays in the last bar.
   always_comb begin
      bar_pix_d = '0;
      bar_idx_d = '0;
      if (!h_wrap && (h_cnt_d < H_ACT)) begin
         if (bar_pix_q == BAR_LAST) begin
            bar_idx_d = (bar_idx_q == 3'd7) ? bar_idx_q : bar_idx_q + 1'b1;
         end else begin
            bar_pix_d = bar_pix_q + 1'b1;
            bar_idx_d = bar_idx_q;
         end
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         bar_pix_q <= '0;
         bar_idx_q <= '0;
      end else begin
         bar_pix_q <= bar_pix_d;
         bar_idx_q <= bar_idx_d;
      end
   end

   localparam int PW = 7;
   logic [PW-1:0] pipe_in;
   assign pipe_in = {hs_raw, vs_raw, av_raw, bus.test_mode, bar_idx_q};
`else
   localparam int PW = 3;
   logic [PW-1:0] pipe_in;
   assign pipe_in = {hs_raw, vs_raw, av_raw};
`endif

   logic [PW-1:0] pipe_out;

   generate
      if (DATA_LAT == 0) begin : g_nolat
         assign pipe_out = pipe_in;
      end else begin : g_lat
         logic [PW-1:0] stage_q [DATA_LAT];
         always_ff @(posedge pclk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DATA_LAT; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= pipe_in;
               for (int i = 1; i < DATA_LAT; i++) stage_q[i] <= stage_q[i-1];
            end
         end
         assign pipe_out = stage_q[DATA_LAT-1];
      end
   endgenerate

   logic            dly_hs, dly_vs, dly_av;
   logic [3*CW-1:0] pix_dat;
   assign dly_hs = pipe_out[PW-1];
   assign dly_vs = pipe_out[PW-2];
   assign dly_av = pipe_out[PW-3];

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar_rgb;
   always_comb begin
      bar_rgb = 3'b000;
      case (pipe_out[2:0])
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase
      pix_dat = pipe_out[3] ? {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}}
                            : bus.vga_data;
   end
`else
   assign pix_dat = bus.vga_data;
`endif

   logic            hsync_q, vsync_q, valid_q, frame_start_q;
   logic [3*CW-1:0] colour_q;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         hsync_q       <= ~HS_LVL;
         vsync_q       <= ~VS_LVL;
         valid_q       <= 1'b0;
         colour_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= dly_hs ? HS_LVL : ~HS_LVL;
         vsync_q       <= dly_vs ? VS_LVL : ~VS_LVL;
         valid_q       <= dly_av;
         colour_q      <= dly_av ? pix_dat : '0;
         frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   assign bus.h_addr      = h_act ? ADDR_W'(h_cnt_q) : '0;
   assign bus.v_addr      = v_act ? ADDR_W'(v_cnt_q) : '0;
   assign bus.h_char      = h_char_q;
   assign bus.v_char      = v_char_q;
   assign bus.h_font      = h_font_q;
   assign bus.v_font      = v_font_q;
   assign bus.addr_valid  = av_raw;
   assign bus.frame_start = frame_start_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.valid       = valid_q;
   assign bus.vga_r       = colour_q[3*CW-1:2*CW];
   assign bus.vga_g       = colour_q[2*CW-1:CW];
   assign bus.vga_b       = colour_q[CW-1:0];
endmodule
